// File: rtl/count_checker_4bit_if.sv
// Sample/result bundle between a counter source and count_checker_4bit.
// The source drives the sample side; the checker answers with lock/error status.
interface count_checker_4bit_if #(
  parameter int unsigned ERR_W = 8
);
  logic             en;
  logic             sel;
  logic [3:0]       cnt_in;
  logic             clr_err;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, sel, cnt_in, clr_err,
    input  locked, err, wrap, err_cnt
  );

  modport slave (
    input  en, sel, cnt_in, clr_err,
    output locked, err, wrap, err_cnt
  );
endinterface

// File: rtl/count_checker_4bit.sv
// Watches a 4-bit up/down counter, locks after LOCK_LEN good steps and
// flags/counts step errors while locked.
module count_checker_4bit #(
  parameter int unsigned LOCK_LEN = 2,
  parameter int unsigned ERR_W    = 8
) (
  input logic                 clk,
  input logic                 rst,
  count_checker_4bit_if.slave bus
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SYNC     = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic [3:0] prev;
  logic [3:0] run;
  logic [1:0] rst_sync;
  logic       ready;
  logic       accept;
  logic       match;
  logic       wrap_step;
  logic       inc_err;
  logic [3:0] exp_val;

  // Release synchroniser: samples are ignored until two edges after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end

  assign ready = ~rst_sync[1];

  always_comb begin
    accept    = bus.en & ready;
    exp_val   = bus.sel ? (prev + 4'd1) : (prev - 4'd1);
    match     = (bus.cnt_in == exp_val);
    wrap_step = bus.sel ? ((prev == 4'hF) && (bus.cnt_in == 4'h0))
                        : ((prev == 4'h0) && (bus.cnt_in == 4'hF));
    inc_err   = accept && (state == LOCKED) && !match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNLOCKED;
      prev        <= 4'd0;
      run         <= 4'd0;
      bus.locked  <= 1'b0;
      bus.err     <= 1'b0;
      bus.wrap    <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      bus.err  <= 1'b0;
      bus.wrap <= 1'b0;
      if (accept) begin
        prev <= bus.cnt_in;
        unique case (state)
          UNLOCKED: begin
            run        <= 4'd0;
            state      <= SYNC;
            bus.locked <= 1'b0;
          end
          SYNC: begin
            if (match) begin
              run <= run + 4'd1;
              if ((run + 4'd1) == 4'(LOCK_LEN)) begin
                state      <= LOCKED;
                bus.locked <= 1'b1;
              end
            end else begin
              run <= 4'd0;
            end
          end
          LOCKED: begin
            if (match) begin
              bus.wrap <= wrap_step;
            end else begin
              bus.err    <= 1'b1;
              run        <= 4'd0;
              state      <= SYNC;
              bus.locked <= 1'b0;
            end
          end
          default: begin
            run        <= 4'd0;
            state      <= UNLOCKED;
            bus.locked <= 1'b0;
          end
        endcase
      end
      // Clear wins over a same-cycle increment; the count never wraps.
      if (bus.clr_err)
        bus.err_cnt <= '0;
      else if (inc_err && (bus.err_cnt != CNT_MAX))
        bus.err_cnt <= bus.err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_count_checker_4bit.sv
// Scoreboard bench for count_checker_4bit: a behavioural model pushes the
// expected outputs per driven cycle, popped and compared one edge later.
module tb_count_checker_4bit;

  localparam int unsigned LOCK_LEN = 2;
  localparam int unsigned ERR_W    = 2;
  localparam int          CNT_MAX  = (1 << ERR_W) - 1;

  typedef struct packed {
    logic             locked;
    logic             err;
    logic             wrap;
    logic [ERR_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  count_checker_4bit_if #(.ERR_W(ERR_W)) bus ();

  count_checker_4bit #(.LOCK_LEN(LOCK_LEN), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_state = 0;
  int m_prev  = 0;
  int m_run   = 0;
  int m_cnt   = 0;
  int m_rdy   = 0;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_run = 0; m_cnt = 0; m_rdy = 0;
  endtask

  // Advance the model by one clock edge and queue the outputs it predicts.
  task automatic model(input logic e, input logic s, input logic [3:0] c, input logic clr);
    exp_t x;
    bit   acc, ok, e_err, e_wrap;
    int   nxt;
    acc    = e && (m_rdy >= 2);
    if (m_rdy < 2) m_rdy++;
    e_err  = 0;
    e_wrap = 0;
    if (acc) begin
      nxt = s ? (m_prev + 1) % 16 : (m_prev + 15) % 16;
      ok  = (int'(c) == nxt);
      if (m_state == 0) begin
        m_state = 1; m_run = 0;
      end else if (m_state == 1) begin
        if (ok) begin
          m_run++;
          if (m_run == LOCK_LEN) m_state = 2;
        end else m_run = 0;
      end else begin
        if (ok) e_wrap = (s && m_prev == 15 && c == 0) || (!s && m_prev == 0 && c == 15);
        else begin
          e_err = 1; m_run = 0; m_state = 1;
        end
      end
      m_prev = int'(c);
    end
    if (clr) m_cnt = 0;
    else if (e_err && m_cnt < CNT_MAX) m_cnt++;
    x.locked = (m_state == 2);
    x.err    = e_err;
    x.wrap   = e_wrap;
    x.cnt    = ERR_W'(m_cnt);
    sb.push_back(x);
  endtask

  // Called at a falling edge: drive, predict, compare after the rising edge.
  task automatic step(input logic e, input logic s, input logic [3:0] c, input logic clr = 1'b0);
    exp_t x;
    bus.en = e; bus.sel = s; bus.cnt_in = c; bus.clr_err = clr;
    model(e, s, c, clr);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      check("locked",  int'(bus.locked),  int'(x.locked));
      check("err",     int'(bus.err),     int'(x.err));
      check("wrap",    int'(bus.wrap),    int'(x.wrap));
      check("err_cnt", int'(bus.err_cnt), int'(x.cnt));
    end
    @(negedge clk);
  endtask

  initial begin
    bus.en = 1'b0; bus.sel = 1'b0; bus.cnt_in = 4'd0; bus.clr_err = 1'b0;
    #1;
    check("rst_locked",  int'(bus.locked),  0);
    check("rst_err",     int'(bus.err),     0);
    check("rst_wrap",    int'(bus.wrap),    0);
    check("rst_err_cnt", int'(bus.err_cnt), 0);

    // Release with en already high: the first two edges must not accept.
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 1, 4'd2);
    step(1, 1, 4'd2);
    step(1, 1, 4'd3);
    step(1, 1, 4'd4);
    step(1, 1, 4'd5);

    // Count up through the 15->0 wrap.
    for (int v = 6; v <= 17; v++) step(1, 1, 4'(v % 16));

    // Up to 7, turn around legally, then a bad down step.
    for (int v = 2; v <= 7; v++) step(1, 1, 4'(v));
    step(1, 0, 4'd6);
    step(1, 0, 4'd5);
    step(1, 0, 4'd6);

    // Clear, relock to 9, counter glitch to 0, relock.
    step(0, 1, 4'd0, 1'b1);
    step(1, 1, 4'd7);
    step(1, 1, 4'd8);
    step(1, 1, 4'd9);
    step(1, 1, 4'd0);
    step(1, 1, 4'd1);
    step(1, 1, 4'd2);

    // en low with a wandering counter must change nothing.
    for (int i = 0; i < 4; i++) step(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    step(1, 1, 4'd3);

    // Asynchronous reset pulse between edges.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_locked",  int'(bus.locked),  0);
    check("async_err_cnt", int'(bus.err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 0, 4'd8);
    step(1, 0, 4'd8);
    step(1, 0, 4'd8);
    step(1, 0, 4'd7);
    step(1, 0, 4'd6);

    // Five repeat-value errors with relock between: count saturates.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 4'(m_prev));
      step(1, 0, 4'((m_prev + 15) % 16));
      step(1, 0, 4'((m_prev + 15) % 16));
    end
    check("sat_err_cnt", int'(bus.err_cnt), CNT_MAX);

    // Clear together with an error: err pulses, count goes to zero.
    step(1, 0, 4'(m_prev), 1'b1);
    step(0, 0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
